// File: rtl/dsp48e2.sv
// dsp48e2: reduced DSP slice (27x18 mult, X/Y/Z/W muxes, SIMD ALU, optional P reg); in: clock reset ce a b c alumode opmode carryin, out: p carryout
module dsp48e2 #(
  parameter int USE_SIMD = 0,
  parameter int PREG = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic [29:0] a,
  input  logic [17:0] b,
  input  logic [47:0] c,
  input  logic [3:0]  alumode,
  input  logic [8:0]  opmode,
  input  logic        carryin,
  output logic [47:0] p,
  output logic [3:0]  carryout
);
  localparam int LW = 48 >> USE_SIMD;
  localparam int NL = 48 / LW;
  localparam int CS = 4 / NL;
  logic signed [44:0] prod;
  logic [47:0] m, ab, p_fb, x, y, z, w, r, p_reg;
  logic [3:0] cy, c_reg;
  logic [NL-1:0] lc;
  logic sub_z, inv_r;
  assign prod = $signed(a[26:0]) * $signed(b);
  assign m = USE_SIMD == 0 ? {{3{prod[44]}}, prod} : '0;
  assign ab = {a, b};
  assign p_fb = PREG != 0 ? p_reg : '0;
  assign x = opmode[1:0] == 2'b01 ? m : opmode[1:0] == 2'b10 ? p_fb : opmode[1:0] == 2'b11 ? ab : '0;
  assign y = opmode[3:2] == 2'b10 ? '1 : opmode[3:2] == 2'b11 ? c : '0;
  assign z = opmode[6:4] == 3'b010 ? p_fb : opmode[6:4] == 3'b011 ? c : '0;
  assign w = opmode[8:7] == 2'b01 ? p_fb : opmode[8:7] == 2'b11 ? c : '0;
  assign sub_z = alumode == 4'b0001 || alumode == 4'b0011;
  assign inv_r = alumode == 4'b0010 || alumode == 4'b0011;
  for (genvar i = 0; i < NL; i++) begin : g_lane
    logic [LW-1:0] s, zz, sum;
    logic co;
    assign s = w[i*LW +: LW] + x[i*LW +: LW] + y[i*LW +: LW] + LW'(i == 0 ? carryin : 1'b0);
    assign zz = z[i*LW +: LW] ^ {LW{sub_z}};
    assign {co, sum} = {1'b0, zz} + {1'b0, s};
    assign r[i*LW +: LW] = sum ^ {LW{inv_r}};
    assign lc[i] = co;
  end
  always_comb begin
    cy = '0;
    for (int k = 0; k < NL; k++) cy[k*CS + CS - 1] = lc[k];
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      p_reg <= '0;
      c_reg <= '0;
    end else if (ce) begin
      p_reg <= r;
      c_reg <= cy;
    end
  assign p = PREG != 0 ? p_reg : r;
  assign carryout = PREG != 0 ? c_reg : cy;
endmodule

// File: tb/tb_dsp48e2.sv
// tb_dsp48e2: directed and randomized checks of dsp48e2 across SIMD/PREG variants against a lane-arithmetic model
module tb_dsp48e2;
  logic clock, reset, ce, carryin;
  logic [29:0] a;
  logic [17:0] b;
  logic [47:0] c;
  logic [3:0] alumode;
  logic [8:0] opmode;
  logic [47:0] p0, p1, p2, p3, p4;
  logic [3:0] co0, co1, co2, co3, co4;
  logic [51:0] e3, e4;
  int nvec = 0;
  int nerr = 0;
  dsp48e2 #(.USE_SIMD(0), .PREG(0)) d0 (.clock(clock), .reset(reset), .ce(ce), .a(a), .b(b), .c(c), .alumode(alumode), .opmode(opmode), .carryin(carryin), .p(p0), .carryout(co0));
  dsp48e2 #(.USE_SIMD(1), .PREG(0)) d1 (.clock(clock), .reset(reset), .ce(ce), .a(a), .b(b), .c(c), .alumode(alumode), .opmode(opmode), .carryin(carryin), .p(p1), .carryout(co1));
  dsp48e2 #(.USE_SIMD(2), .PREG(0)) d2 (.clock(clock), .reset(reset), .ce(ce), .a(a), .b(b), .c(c), .alumode(alumode), .opmode(opmode), .carryin(carryin), .p(p2), .carryout(co2));
  dsp48e2 #(.USE_SIMD(0), .PREG(1)) d3 (.clock(clock), .reset(reset), .ce(ce), .a(a), .b(b), .c(c), .alumode(alumode), .opmode(opmode), .carryin(carryin), .p(p3), .carryout(co3));
  dsp48e2 #(.USE_SIMD(2), .PREG(1)) d4 (.clock(clock), .reset(reset), .ce(ce), .a(a), .b(b), .c(c), .alumode(alumode), .opmode(opmode), .carryin(carryin), .p(p4), .carryout(co4));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [51:0] got, input logic [51:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  function automatic logic [51:0] model(input int simd, input logic [47:0] pf);
    logic signed [63:0] prod;
    logic [63:0] m, ab, x, y, z, w, lm, s, zk, t, r, pr;
    logic [3:0] cy;
    int l;
    prod = $signed(a[26:0]) * $signed(b);
    m = simd == 0 ? prod & 64'hFFFF_FFFF_FFFF : 64'h0;
    ab = {16'h0, a, b};
    case (opmode[1:0]) 2'd0: x = 0; 2'd1: x = m; 2'd2: x = {16'h0, pf}; default: x = ab; endcase
    case (opmode[3:2]) 2'd2: y = 64'hFFFF_FFFF_FFFF; 2'd3: y = {16'h0, c}; default: y = 0; endcase
    case (opmode[6:4]) 3'd2: z = {16'h0, pf}; 3'd3: z = {16'h0, c}; default: z = 0; endcase
    case (opmode[8:7]) 2'd1: w = {16'h0, pf}; 2'd3: w = {16'h0, c}; default: w = 0; endcase
    l = 48 >> simd;
    lm = (64'd1 << l) - 1;
    pr = 0;
    cy = 0;
    for (int k = 0; k < 48 / l; k++) begin
      s = (((w >> (k*l)) & lm) + ((x >> (k*l)) & lm) + ((y >> (k*l)) & lm) + 64'(k == 0 && carryin)) & lm;
      zk = (z >> (k*l)) & lm;
      t = (alumode == 4'b0001 || alumode == 4'b0011) ? (lm - zk) + s : zk + s;
      r = (alumode == 4'b0010 || alumode == 4'b0011) ? lm - (t & lm) : t & lm;
      pr = pr | (r << (k*l));
      cy[simd == 0 ? 3 : simd == 1 ? 2*k + 1 : k] = t[l];
    end
    return {cy, pr[47:0]};
  endfunction
  initial begin
    clock = 0; reset = 1; ce = 1; a = 0; b = 0; c = 0; alumode = 0; opmode = 0; carryin = 0;
    #2;
    chk("reset_d3", {co3, p3}, 52'h0);
    chk("reset_d4", {co4, p4}, 52'h0);
    {a, b} = 48'h001_001_0C8_003; c = 48'h7FF_000_064_005; opmode = 9'b000110011; alumode = 4'b0011;
    #1;
    chk("four12_sub", {4'h0, p2}, {4'h0, 48'h7FE_FFF_F9C_002});
    chk("four12_sub_model", {co2, p2}, model(2, 48'h0));
    alumode = 4'b0000; c = 48'h0000_FFFF_FFFF; {a, b} = 48'h1; carryin = 1;
    #1;
    chk("one48_add", {co0, p0}, {4'h0, 48'h0001_0000_0001});
    carryin = 0; opmode = 9'b000000001; a = 30'h3FFF_FFFD; b = 18'd7;
    #1;
    chk("mul_neg", {4'h0, p0}, {4'h0, 48'hFFFF_FFFF_FFEB});
    chk("mul_simd_zero", {co1, p1}, 52'h0);
    opmode = 9'b000100011; c = 0; {a, b} = 48'd5; ce = 1;
    tick();
    chk("acc_in_reset", {4'h0, p3}, 52'h0);
    reset = 0;
    tick(); chk("acc_5", {4'h0, p3}, 52'd5);
    tick(); chk("acc_10", {4'h0, p3}, 52'd10);
    tick(); chk("acc_15", {4'h0, p3}, 52'd15);
    ce = 0;
    tick(); chk("acc_hold", {4'h0, p3}, 52'd15);
    ce = 1;
    tick(); chk("acc_20", {4'h0, p3}, 52'd20);
    #1 reset = 1;
    #1 chk("async_reset", {co3, p3}, 52'h0);
    tick(); chk("reset_held", {co3, p3}, 52'h0);
    reset = 0;
    tick(); chk("acc_restart", {4'h0, p3}, 52'd5);
    opmode = 9'b000110011; alumode = 4'b0000; c = 48'h000001_FFFFFF; {a, b} = 48'h000001_000001;
    #1;
    chk("two24_ovf", {co1, p1}, {4'b0010, 48'h000002_000000});
    reset = 1;
    tick();
    reset = 0;
    e3 = 0;
    e4 = 0;
    repeat (300) begin
      a = 30'($urandom); b = 18'($urandom); c = {16'($urandom), 32'($urandom)};
      alumode = ($urandom % 3 == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      opmode = 9'($urandom); carryin = 1'($urandom); ce = ($urandom % 4) != 0;
      #1;
      chk("rnd_d0", {co0, p0}, model(0, 48'h0));
      chk("rnd_d1", {co1, p1}, model(1, 48'h0));
      chk("rnd_d2", {co2, p2}, model(2, 48'h0));
      if (ce) begin
        e3 = model(0, e3[47:0]);
        e4 = model(2, e4[47:0]);
      end
      tick();
      chk("rnd_d3", {co3, p3}, e3);
      chk("rnd_d4", {co4, p4}, e4);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
